// File: rtl/rsa_pkg.sv
// Shared types and helpers for the sequential RSA modular exponentiator.
// Holds the controller state encoding and the busy-length formula.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REDUCE,
        MUL,
        SQR,
        FIN
    } state_t;

    // Accumulator headroom: W+2 bits hold anything below 3*C.
    localparam int ACC_GUARD = 2;

    function automatic int busy_cycles(
        input int          w,
        input logic [63:0] b,
        input bit          degenerate
    );
        int k;
        int p;
        k = 0;
        p = 0;
        if (degenerate) return 1;
        for (int i = 0; i < 64; i++) begin
            if (b[i]) begin
                k = i + 1;
                p = p + 1;
            end
        end
        return 1 + w * (1 + k + p);
    endfunction

endpackage

// File: rtl/rsa_modmul_seq.sv
// Interleaved shift-add (Blakley) modular multiplier, one bit of X per cycle.
// The go cycle already consumes the MSB, so done pulses W cycles after go.
import rsa_pkg::*;

module rsa_modmul_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    input  logic [W-1:0] M,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] P
);

    localparam int ACCW = W + ACC_GUARD;
    localparam int CW   = $clog2(W + 1);

    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] acc_in;
    logic [ACCW-1:0] acc_nxt;
    logic [W-1:0]    xs;
    logic [W-1:0]    y;
    logic [W-1:0]    m;
    logic [W-1:0]    y_in;
    logic [W-1:0]    m_in;
    logic            bit_in;
    logic [CW-1:0]   cnt;

    always_comb begin
        acc_in  = go ? '0 : acc;
        bit_in  = go ? X[W-1] : xs[W-1];
        y_in    = go ? Y : y;
        m_in    = go ? M : m;
        acc_nxt = {acc_in[ACCW-2:0], 1'b0};
        if (bit_in) acc_nxt = acc_nxt + ACCW'(y_in);
        if (acc_nxt >= ACCW'(m_in)) acc_nxt = acc_nxt - ACCW'(m_in);
        if (acc_nxt >= ACCW'(m_in)) acc_nxt = acc_nxt - ACCW'(m_in);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            xs   <= '0;
            y    <= '0;
            m    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go) begin
                acc  <= acc_nxt;
                xs   <= {X[W-2:0], 1'b0};
                y    <= Y;
                m    <= M;
                cnt  <= CW'(W - 1);
                busy <= 1'b1;
            end else if (busy) begin
                acc <= acc_nxt;
                xs  <= {xs[W-2:0], 1'b0};
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign P = acc[W-1:0];

endmodule

// File: rtl/rsa_modexp_seq.sv
// Right-to-left square-and-multiply modular exponentiator, Yn = A^B mod C.
// One shared modmul serves REDUCE, MUL and SQR; the next go overlaps the last cycle.
import rsa_pkg::*;

module rsa_modexp_seq #(
    parameter int W  = 8,
    parameter int EW = W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  A,
    input  logic [EW-1:0] B,
    input  logic [W-1:0]  C,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  Yn
);

    state_t state;
    state_t state_n;

    logic [W-1:0]  a_r;
    logic [W-1:0]  m_r;
    logic [W-1:0]  r;
    logic [W-1:0]  base;
    logic [W-1:0]  base_eff;
    logic [EW-1:0] e;
    logic [EW-1:0] e_sh;
    logic [W-1:0]  mm_x;
    logic [W-1:0]  mm_y;
    logic [W-1:0]  mm_p;
    logic          mm_go;
    logic          mm_go_req;
    logic          mm_busy;
    logic          mm_done;

    rsa_modmul_seq #(.W(W)) u_mm (
        .clk  (clk),
        .rst  (rst),
        .go   (mm_go),
        .X    (mm_x),
        .Y    (mm_y),
        .M    (m_r),
        .busy (mm_busy),
        .done (mm_done),
        .P    (mm_p)
    );

    // The base written by the phase now ending is not registered yet.
    assign base_eff = (state == REDUCE || state == SQR) ? mm_p : base;
    assign e_sh     = e >> 1;
    assign mm_go    = mm_go_req & ~mm_busy;

    always_comb begin
        state_n   = state;
        mm_go_req = 1'b0;
        mm_x      = r;
        mm_y      = base_eff;
        unique case (state)
            IDLE: begin
                if (start) state_n = CHECK;
            end
            CHECK: begin
                if (m_r <= W'(1)) begin
                    state_n = FIN;
                end else begin
                    mm_go_req = 1'b1;
                    mm_x      = a_r;
                    mm_y      = W'(1);
                    state_n   = REDUCE;
                end
            end
            REDUCE: begin
                if (mm_done) begin
                    if (e == '0) begin
                        state_n = FIN;
                    end else begin
                        mm_go_req = 1'b1;
                        if (e[0]) begin
                            state_n = MUL;
                        end else begin
                            mm_x    = base_eff;
                            state_n = SQR;
                        end
                    end
                end
            end
            MUL: begin
                if (mm_done) begin
                    mm_go_req = 1'b1;
                    mm_x      = base_eff;
                    state_n   = SQR;
                end
            end
            SQR: begin
                if (mm_done) begin
                    if (e_sh == '0) begin
                        state_n = FIN;
                    end else begin
                        mm_go_req = 1'b1;
                        if (e_sh[0]) begin
                            state_n = MUL;
                        end else begin
                            mm_x    = base_eff;
                            state_n = SQR;
                        end
                    end
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            m_r   <= '0;
            e     <= '0;
            r     <= '0;
            base  <= '0;
            err   <= 1'b0;
            Yn    <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r <= A;
                        e   <= B;
                        m_r <= C;
                        err <= 1'b0;
                        Yn  <= '0;
                    end
                end
                CHECK: begin
                    err <= (m_r == '0);
                    if (m_r > W'(1)) r <= W'(1);
                end
                REDUCE: begin
                    if (mm_done) begin
                        base <= mm_p;
                        if (e == '0) Yn <= r;
                    end
                end
                MUL: begin
                    if (mm_done) r <= mm_p;
                end
                SQR: begin
                    if (mm_done) begin
                        base <= mm_p;
                        e    <= e_sh;
                        if (e_sh == '0) Yn <= r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == CHECK) || (state == REDUCE) ||
                  (state == MUL) || (state == SQR);
    assign done = (state == FIN);

endmodule

// File: tb/tb_rsa_modexp_seq.sv
// Self-checking bench for rsa_modexp_seq at W=8 and W=16.
// Results come from a plain-arithmetic square-and-multiply reference.
import rsa_pkg::*;

module tb_rsa_modexp_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, c8 = '0;
    logic        busy8, done8, err8;
    logic [7:0]  yn8;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, c16 = '0;
    logic        busy16, done16, err16;
    logic [15:0] yn16;

    rsa_modexp_seq #(.W(8)) u8 (
        .clk(clk), .rst(rst), .start(start8),
        .A(a8), .B(b8), .C(c8),
        .busy(busy8), .done(done8), .err(err8), .Yn(yn8)
    );

    rsa_modexp_seq #(.W(16)) u16 (
        .clk(clk), .rst(rst), .start(start16),
        .A(a16), .B(b16), .C(c16),
        .busy(busy16), .done(done16), .err(err16), .Yn(yn16)
    );

    int checks = 0;
    int errors = 0;
    bit wide = 1'b0;

    logic        s_busy, s_done, s_err;
    logic [15:0] s_yn;

    always_comb begin
        s_busy = wide ? busy16 : busy8;
        s_done = wide ? done16 : done8;
        s_err  = wide ? err16 : err8;
        s_yn   = wide ? yn16 : {8'h00, yn8};
    end

    function automatic logic [16:0] ref_exp(
        input logic [15:0] a, input logic [15:0] b, input logic [15:0] c
    );
        longint unsigned r, bs, m, la;
        logic [15:0] ex;
        if (c == 16'd0) return {1'b1, 16'h0000};
        if (c == 16'd1) return 17'h0;
        m  = longint'(c);
        la = longint'(a);
        r  = 1;
        bs = la % m;
        ex = b;
        while (ex != 16'd0) begin
            if (ex[0]) r = (r * bs) % m;
            bs = (bs * bs) % m;
            ex = ex >> 1;
        end
        return {1'b0, r[15:0]};
    endfunction

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c);
        if (wide) begin
            a16 = a; b16 = b; c16 = c;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; c8 = c[7:0];
        end
    endtask

    task automatic set_start(input logic v);
        if (wide) start16 = v;
        else start8 = v;
    endtask

    task automatic run(
        input  logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
        input  bit          hold, input logic [15:0] a2,
        output logic [15:0] yn, output logic er, output int nb,
        output logic b_done, output logic d_after, output logic b_after,
        output bit tmo
    );
        @(negedge clk);
        drive(a, b, c);
        set_start(1'b1);
        @(negedge clk);
        if (!hold) set_start(1'b0);
        nb  = 0;
        tmo = 1'b0;
        while (!s_done) begin
            if (s_busy) nb++;
            if (hold) begin
                if (nb == 10) drive(a2, b, c);
            end else begin
                drive(16'($urandom), 16'($urandom), 16'($urandom));
            end
            if (nb > 5000) begin
                tmo = 1'b1;
                break;
            end
            @(negedge clk);
        end
        yn     = s_yn;
        er     = s_err;
        b_done = s_busy;
        @(negedge clk);
        d_after = s_done;
        b_after = s_busy;
    endtask

    logic [15:0] yn;
    logic        er, bd, da, ba;
    int          nb;
    bit          tmo;
    logic [16:0] exp_v;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy8, done8, err8, yn8} !== 11'h0) begin
            errors++;
            $display("FAIL reset_w8: got %h want 0", {busy8, done8, err8, yn8});
        end
        checks++;
        if ({busy16, done16, err16, yn16} !== 19'h0) begin
            errors++;
            $display("FAIL reset_w16: got %h want 0",
                     {busy16, done16, err16, yn16});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        wide = 1'b0;
        run(16'h2b, 16'h05, 16'h3a, 1'b0, 16'h0, yn, er, nb, bd, da, ba, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL basic_timeout: no done"); end
        checks++;
        if (yn !== 16'h13 || er !== 1'b0) begin
            errors++;
            $display("FAIL basic_yn: got %h err %b want 13 err 0", yn, er);
        end
        checks++;
        if (nb !== 49) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 49", nb);
        end
        checks++;
        if (bd !== 1'b0 || da !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: busy@done %b done+1 %b want 0 0",
                     bd, da);
        end
    endtask

    task automatic test_a_ge_c();
        wide = 1'b0;
        run(16'hf7, 16'h05, 16'ha1, 1'b0, 16'h0, yn, er, nb, bd, da, ba, tmo);
        checks++;
        if (tmo || yn !== 16'h43 || er !== 1'b0) begin
            errors++;
            $display("FAIL a_ge_c_yn: got %h err %b tmo %b want 43", yn, er, tmo);
        end
        checks++;
        if (nb !== 49) begin
            errors++;
            $display("FAIL a_ge_c_latency: got %0d want 49", nb);
        end
        run(16'haf, 16'h00, 16'h0f, 1'b0, 16'h0, yn, er, nb, bd, da, ba, tmo);
        checks++;
        if (tmo || yn !== 16'h01 || er !== 1'b0) begin
            errors++;
            $display("FAIL b_zero_yn: got %h err %b tmo %b want 01", yn, er, tmo);
        end
        checks++;
        if (nb !== 9) begin
            errors++;
            $display("FAIL b_zero_latency: got %0d want 9", nb);
        end
    endtask

    task automatic test_degenerate();
        wide = 1'b0;
        run(16'h10, 16'h03, 16'h00, 1'b0, 16'h0, yn, er, nb, bd, da, ba, tmo);
        checks++;
        if (tmo || er !== 1'b1 || yn !== 16'h00 || nb !== 1) begin
            errors++;
            $display("FAIL c_zero: got err %b yn %h busy %0d want 1 00 1",
                     er, yn, nb);
        end
        checks++;
        if (s_err !== 1'b1) begin
            errors++;
            $display("FAIL c_zero_err_held: got %b want 1", s_err);
        end
        run(16'h10, 16'h03, 16'h01, 1'b0, 16'h0, yn, er, nb, bd, da, ba, tmo);
        checks++;
        if (tmo || er !== 1'b0 || yn !== 16'h00 || nb !== 1) begin
            errors++;
            $display("FAIL c_one: got err %b yn %h busy %0d want 0 00 1",
                     er, yn, nb);
        end
    endtask

    task automatic test_wide16();
        logic [15:0] a, b, c;
        int          lat;
        wide = 1'b1;
        run(16'h0002, 16'h0010, 16'hfff1, 1'b0, 16'h0,
            yn, er, nb, bd, da, ba, tmo);
        checks++;
        if (tmo || yn !== 16'h000f || er !== 1'b0 || nb !== 113) begin
            errors++;
            $display("FAIL w16_directed: got yn %h err %b busy %0d want 000f 0 113",
                     yn, er, nb);
        end
        for (int i = 0; i < 50; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            c = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 2))
                                            : 16'($urandom);
            exp_v = ref_exp(a, b, c);
            lat   = busy_cycles(16, {48'h0, b}, c <= 16'd1);
            run(a, b, c, 1'b0, 16'h0, yn, er, nb, bd, da, ba, tmo);
            checks++;
            if (tmo || {er, yn} !== exp_v || nb !== lat) begin
                errors++;
                $display("FAIL w16_rand: A=%h B=%h C=%h got %h/%0d want %h/%0d",
                         a, b, c, {er, yn}, nb, exp_v, lat);
            end
        end
    endtask

    task automatic test_random8();
        logic [15:0] a, b, c;
        int          lat;
        wide = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a = {8'h00, 8'($urandom)};
            b = {8'h00, 8'($urandom)};
            c = {8'h00, 8'($urandom_range(0, 255))};
            exp_v = ref_exp(a, b, c);
            lat   = busy_cycles(8, {48'h0, b}, c <= 16'd1);
            run(a, b, c, 1'b0, 16'h0, yn, er, nb, bd, da, ba, tmo);
            checks++;
            if (tmo || {er, yn} !== exp_v || nb !== lat) begin
                errors++;
                $display("FAIL w8_rand: A=%h B=%h C=%h got %h/%0d want %h/%0d",
                         a, b, c, {er, yn}, nb, exp_v, lat);
            end
        end
    endtask

    task automatic test_start_held();
        int n;
        wide = 1'b0;
        run(16'h2b, 16'h05, 16'h3a, 1'b1, 16'h07, yn, er, nb, bd, da, ba, tmo);
        checks++;
        if (tmo || yn !== 16'h13 || nb !== 49) begin
            errors++;
            $display("FAIL held_yn: got %h busy %0d want 13 49", yn, nb);
        end
        checks++;
        if (ba !== 1'b0 || da !== 1'b0) begin
            errors++;
            $display("FAIL held_gap: busy %b done %b after done want 0 0", ba, da);
        end
        @(negedge clk);
        checks++;
        if (s_busy !== 1'b1) begin
            errors++;
            $display("FAIL held_restart: busy %b want 1", s_busy);
        end
        set_start(1'b0);
        n = 0;
        while (!s_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        exp_v = ref_exp(16'h07, 16'h05, 16'h3a);
        checks++;
        if (n >= 2000 || {s_err, s_yn} !== exp_v) begin
            errors++;
            $display("FAIL held_second: got %h want %h", {s_err, s_yn}, exp_v);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int pulses;
        wide = 1'b0;
        @(negedge clk);
        drive(16'h2b, 16'h05, 16'h3a);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, err8, yn8} !== 11'h0) begin
            errors++;
            $display("FAIL reset_mid: got %h want 0", {busy8, done8, err8, yn8});
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (60) begin
            @(negedge clk);
            if (done8 || busy8) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %0d active cycles want 0", pulses);
        end
        run(16'h2b, 16'h05, 16'h3a, 1'b0, 16'h0, yn, er, nb, bd, da, ba, tmo);
        checks++;
        if (tmo || yn !== 16'h13 || er !== 1'b0 || nb !== 49) begin
            errors++;
            $display("FAIL reset_mid_rerun: got %h busy %0d want 13 49", yn, nb);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_a_ge_c();
        test_degenerate();
        test_start_held();
        test_reset_mid();
        test_random8();
        test_wide16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
